// File: rtl/lsu_arbiter.sv
// lsu_arbiter
//   Shares the single load/store unit between the two issue lanes of the
//   dual-issue core. Memory ops presented by the execute stage are captured
//   into a two-entry queue and issued to the LSU in program order (lane1 is
//   the older lane). The front end is stalled until every captured op has
//   retired. Load data is returned with its destination register for
//   writeback. Control can flush the block on a taken jump.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   flush               kill captured/pending ops
//   req{1,2}_*          per-lane op from execute: valid, store, size, addr,
//                       wdata, rd
//   lsu_req_valid/ready request handshake to the LSU
//   lsu_store/size/addr/wdata  request payload (zero when no request)
//   lsu_done, lsu_rdata completion pulse from the LSU, load data with it
//   stall               hold decode/execute
//   res_valid/lane/rd/data  one-cycle load result for writeback
//   misalign/misalign_lane  one-cycle pulse when an op is dropped
module lsu_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              req1_valid,
  input  logic              req1_store,
  input  logic [1:0]        req1_size,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  input  logic [4:0]        req1_rd,
  input  logic              req2_valid,
  input  logic              req2_store,
  input  logic [1:0]        req2_size,
  input  logic [ADDR_W-1:0] req2_addr,
  input  logic [DATA_W-1:0] req2_wdata,
  input  logic [4:0]        req2_rd,
  output logic              lsu_req_valid,
  input  logic              lsu_req_ready,
  output logic              lsu_store,
  output logic [1:0]        lsu_size,
  output logic [ADDR_W-1:0] lsu_addr,
  output logic [DATA_W-1:0] lsu_wdata,
  input  logic              lsu_done,
  input  logic [DATA_W-1:0] lsu_rdata,
  output logic              stall,
  output logic              res_valid,
  output logic              res_lane,
  output logic [4:0]        res_rd,
  output logic [DATA_W-1:0] res_data,
  output logic              misalign,
  output logic              misalign_lane
);

  typedef struct packed {
    logic              store;
    logic [1:0]        size;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [4:0]        rd;
    logic              lane;
  } entry_t;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DRAIN, DONE} state_t;

  state_t     state;
  logic [1:0] cnt;
  entry_t     q0;   // head
  entry_t     q1;
  entry_t     lane1_e;
  entry_t     lane2_e;
  logic       head_mis;
  logic       capture;
  logic       accept;
  logic       pop;

  // Byte ops are always aligned; size 3 is handled as a word.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] addr_lo);
    case (size)
      2'd0:    return 1'b0;
      2'd1:    return addr_lo[0];
      default: return addr_lo != 2'b00;
    endcase
  endfunction

  assign lane1_e  = {req1_store, req1_size, req1_addr, req1_wdata, req1_rd, 1'b0};
  assign lane2_e  = {req2_store, req2_size, req2_addr, req2_wdata, req2_rd, 1'b1};
  assign head_mis = is_misaligned(q0.size, q0.addr[1:0]);
  assign capture  = (state == IDLE) && (req1_valid || req2_valid) && !flush;

  // Request is a pure function of registered state, so the payload is
  // stable for as long as the LSU holds ready low. Suppressed during rst so
  // the LSU never takes an op that reset is about to forget.
  assign lsu_req_valid = !rst && (state == ISSUE) && !head_mis;
  assign accept        = lsu_req_valid && lsu_req_ready;
  assign lsu_store     = lsu_req_valid & q0.store;
  assign lsu_size      = {2{lsu_req_valid}} & q0.size;
  assign lsu_addr      = {ADDR_W{lsu_req_valid}} & q0.addr;
  assign lsu_wdata     = {DATA_W{lsu_req_valid}} & q0.wdata;

  // Flush releases the front end in the same cycle so the redirected fetch
  // is not held back.
  assign stall = !rst && !flush &&
                 (capture || (state == ISSUE) || (state == WAIT) || (state == DRAIN));

  // Head retires either by being dropped as misaligned or by LSU completion.
  assign pop = !flush && (((state == ISSUE) && head_mis) ||
                          ((state == WAIT) && lsu_done));

  // Queue storage: data only, occupancy lives in cnt.
  always_ff @(posedge clk) begin
    if (capture) begin
      q0 <= req1_valid ? lane1_e : lane2_e;
      q1 <= lane2_e;
    end else if (pop) begin
      q0 <= q1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      res_valid     <= 1'b0;
      res_lane      <= 1'b0;
      res_rd        <= '0;
      res_data      <= '0;
      misalign      <= 1'b0;
      misalign_lane <= 1'b0;
    end else begin
      res_valid <= 1'b0;
      misalign  <= 1'b0;
      case (state)
        IDLE: begin
          if (capture) begin
            cnt   <= (req1_valid && req2_valid) ? 2'd2 : 2'd1;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          if (flush) begin
            cnt   <= '0;
            // An op accepted this cycle will still complete; wait it out.
            state <= accept ? DRAIN : IDLE;
          end else if (head_mis) begin
            misalign      <= 1'b1;
            misalign_lane <= q0.lane;
            cnt           <= cnt - 2'd1;
            state         <= (cnt == 2'd2) ? ISSUE : DONE;
          end else if (accept) begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (flush) begin
            cnt   <= '0;
            // Completion arriving with the flush needs no draining.
            state <= lsu_done ? IDLE : DRAIN;
          end else if (lsu_done) begin
            if (!q0.store) begin
              res_valid <= 1'b1;
              res_lane  <= q0.lane;
              res_rd    <= q0.rd;
              res_data  <= lsu_rdata;
            end
            cnt   <= cnt - 2'd1;
            state <= (cnt == 2'd2) ? ISSUE : DONE;
          end
        end
        DRAIN: begin
          if (lsu_done) begin
            state <= IDLE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_arbiter.sv
// tb_lsu_arbiter
//   Directed and randomized bench for lsu_arbiter. A transaction-level model
//   turns each captured lane pair into the expected LSU request sequence,
//   misalign drops and load results; an LSU stub answers requests with
//   configurable ready/done latency and supplies load data.
module tb_lsu_arbiter;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic        store;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
  } op_t;

  typedef struct packed {
    logic       lane;
    logic [4:0] rd;
  } res_t;

  logic              clk;
  logic              rst;
  logic              flush;
  logic              req1_valid, req1_store, req2_valid, req2_store;
  logic [1:0]        req1_size, req2_size;
  logic [ADDR_W-1:0] req1_addr, req2_addr;
  logic [DATA_W-1:0] req1_wdata, req2_wdata;
  logic [4:0]        req1_rd, req2_rd;
  logic              lsu_req_valid, lsu_req_ready, lsu_store, lsu_done;
  logic [1:0]        lsu_size;
  logic [ADDR_W-1:0] lsu_addr;
  logic [DATA_W-1:0] lsu_wdata, lsu_rdata;
  logic              stall, res_valid, res_lane, misalign, misalign_lane;
  logic [4:0]        res_rd;
  logic [DATA_W-1:0] res_data;

  lsu_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req1_valid(req1_valid), .req1_store(req1_store), .req1_size(req1_size),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_rd(req1_rd),
    .req2_valid(req2_valid), .req2_store(req2_store), .req2_size(req2_size),
    .req2_addr(req2_addr), .req2_wdata(req2_wdata), .req2_rd(req2_rd),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
    .lsu_store(lsu_store), .lsu_size(lsu_size), .lsu_addr(lsu_addr),
    .lsu_wdata(lsu_wdata), .lsu_done(lsu_done), .lsu_rdata(lsu_rdata),
    .stall(stall), .res_valid(res_valid), .res_lane(res_lane),
    .res_rd(res_rd), .res_data(res_data),
    .misalign(misalign), .misalign_lane(misalign_lane)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running required finished");
    $fatal(1, "watchdog");
  end

  int          tests = 0;
  int          fails = 0;
  op_t         exp_req[$];
  res_t        exp_res[$];
  logic        exp_mis[$];
  logic [31:0] ret_q[$];
  int          done_timer = 0;
  int          ready_wait = 0;
  int          rdy_cfg = 0;
  int          dly_cfg = 1;
  logic        pend_store = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", tag, got, exp);
    end
  endtask

  // Reference model: an op is misaligned when its address is not a multiple
  // of its access width in bytes.
  function automatic bit model_misaligned(input op_t o);
    int nbytes;
    nbytes = (o.size == 2'd0) ? 1 : (o.size == 2'd1) ? 2 : 4;
    return (o.addr % nbytes) != 0;
  endfunction

  task automatic model_push(input op_t a, input logic va, input op_t b, input logic vb);
    op_t  ops[2];
    logic vs[2];
    res_t r;
    ops[0] = a; ops[1] = b; vs[0] = va; vs[1] = vb;
    for (int l = 0; l < 2; l++) begin
      if (vs[l]) begin
        if (model_misaligned(ops[l])) begin
          exp_mis.push_back(1'(l));
        end else begin
          exp_req.push_back(ops[l]);
          if (!ops[l].store) begin
            r.lane = 1'(l);
            r.rd   = ops[l].rd;
            exp_res.push_back(r);
          end
        end
      end
    end
  endtask

  function automatic op_t mk(input logic st, input logic [1:0] sz, input logic [31:0] ad,
                             input logic [4:0] rd);
    op_t o;
    o.store = st; o.size = sz; o.addr = ad; o.rd = rd;
    o.wdata = $urandom;
    return o;
  endfunction

  function automatic op_t rand_op();
    op_t o;
    o.store = 1'($urandom_range(0, 1));
    o.size  = 2'($urandom_range(0, 3));
    o.addr  = $urandom & 32'hFFFF_FFFC;
    if ($urandom_range(0, 2) == 0) o.addr[1:0] = 2'($urandom_range(0, 3));
    o.wdata = $urandom;
    o.rd    = 5'($urandom_range(0, 31));
    return o;
  endfunction

  task automatic drive_lanes(input op_t a, input logic va, input op_t b, input logic vb);
    req1_valid = va; req1_store = a.store; req1_size = a.size;
    req1_addr  = a.addr; req1_wdata = a.wdata; req1_rd = a.rd;
    req2_valid = vb; req2_store = b.store; req2_size = b.size;
    req2_addr  = b.addr; req2_wdata = b.wdata; req2_rd = b.rd;
  endtask

  task automatic clear_lanes();
    op_t z;
    z = '0;
    drive_lanes(z, 1'b0, z, 1'b0);
  endtask

  // Advance to just after the rising edge and update the LSU stub's drives.
  task automatic step();
    @(posedge clk);
    #1;
    lsu_done = 1'b0;
    if (done_timer > 0) begin
      done_timer--;
      if (done_timer == 0) begin
        lsu_done  = 1'b1;
        lsu_rdata = $urandom;
        if (!pend_store) ret_q.push_back(lsu_rdata);
      end
    end
    lsu_req_ready = (ready_wait == 0);
  endtask

  // Mid-cycle: check DUT outputs against the model, then resolve the handshake.
  task automatic sample();
    @(negedge clk);
    if (lsu_req_valid) begin
      if (exp_req.size() == 0) begin
        check_eq("req_unexp", 64'(lsu_req_valid), 64'd0);
      end else begin
        check_eq("req_store", 64'(lsu_store), 64'(exp_req[0].store));
        check_eq("req_size",  64'(lsu_size),  64'(exp_req[0].size));
        check_eq("req_addr",  64'(lsu_addr),  64'(exp_req[0].addr));
        check_eq("req_wdata", 64'(lsu_wdata), 64'(exp_req[0].wdata));
      end
    end
    if (res_valid) begin
      if (exp_res.size() == 0) begin
        check_eq("res_unexp", 64'(res_valid), 64'd0);
      end else begin
        res_t e;
        e = exp_res.pop_front();
        check_eq("res_lane", 64'(res_lane), 64'(e.lane));
        check_eq("res_rd",   64'(res_rd),   64'(e.rd));
        if (ret_q.size() == 0) check_eq("res_data_src", 64'(res_valid), 64'd0);
        else check_eq("res_data", 64'(res_data), 64'(ret_q.pop_front()));
      end
    end
    if (misalign) begin
      if (exp_mis.size() == 0) check_eq("mis_unexp", 64'(misalign), 64'd0);
      else check_eq("mis_lane", 64'(misalign_lane), 64'(exp_mis.pop_front()));
    end
    if (lsu_req_valid) begin
      if (lsu_req_ready) begin
        if (exp_req.size() > 0) void'(exp_req.pop_front());
        done_timer = dly_cfg;
        pend_store = lsu_store;
        ready_wait = rdy_cfg;
      end else if (ready_wait > 0) begin
        ready_wait--;
      end
    end
  endtask

  task automatic cyc();
    step();
    sample();
  endtask

  task automatic check_drained();
    check_eq("q_req",  64'(exp_req.size()), 64'd0);
    check_eq("q_res",  64'(exp_res.size()), 64'd0);
    check_eq("q_mis",  64'(exp_mis.size()), 64'd0);
    check_eq("q_data", 64'(ret_q.size()),   64'd0);
  endtask

  task automatic start_txn(input op_t a, input logic va, input op_t b, input logic vb,
                           input int rdy, input int dly);
    model_push(a, va, b, vb);
    rdy_cfg    = rdy;
    dly_cfg    = dly;
    ready_wait = rdy;
    step();
    drive_lanes(a, va, b, vb);
    sample();
    check_eq("cap_stall", 64'(stall), 64'd1);
  endtask

  // Run until the one-cycle stall release, then check the following idle cycle.
  task automatic finish_txn(input bit garbage);
    int n;
    n = 0;
    while (stall === 1'b1 && n < 200) begin
      step();
      if (garbage) drive_lanes(rand_op(), 1'($urandom_range(0, 1)), rand_op(), 1'($urandom_range(0, 1)));
      else clear_lanes();
      sample();
      n++;
    end
    check_eq("done_stall", 64'(stall), 64'd0);
    step();
    clear_lanes();
    sample();
    check_eq("idle_stall", 64'(stall), 64'd0);
    check_eq("idle_req", 64'(lsu_req_valid), 64'd0);
    check_drained();
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_stall"}, 64'(stall), 64'd0);
    check_eq({tag, "_req"},   64'(lsu_req_valid), 64'd0);
    check_eq({tag, "_addr"},  64'(lsu_addr), 64'd0);
    check_eq({tag, "_resv"},  64'(res_valid), 64'd0);
    check_eq({tag, "_resl"},  64'(res_lane), 64'd0);
    check_eq({tag, "_resrd"}, 64'(res_rd), 64'd0);
    check_eq({tag, "_resd"},  64'(res_data), 64'd0);
    check_eq({tag, "_mis"},   64'(misalign), 64'd0);
    check_eq({tag, "_misl"},  64'(misalign_lane), 64'd0);
  endtask

  initial begin
    op_t z;
    z = '0;
    rst = 1'b1;
    flush = 1'b0;
    lsu_req_ready = 1'b0;
    lsu_done = 1'b0;
    lsu_rdata = '0;
    clear_lanes();
    repeat (3) cyc();
    check_all_zero("rst");
    step();
    rst = 1'b0;
    sample();

    // Single lane1 word load: cycle-exact latency and stall profile.
    start_txn(mk(1'b0, 2'd2, 32'h100, 5'd7), 1'b1, z, 1'b0, 0, 1);
    check_eq("lat_t0_req", 64'(lsu_req_valid), 64'd0);
    step(); clear_lanes(); sample();
    check_eq("lat_t1_req", 64'(lsu_req_valid), 64'd1);
    check_eq("lat_t1_stall", 64'(stall), 64'd1);
    cyc();
    check_eq("lat_t2_req", 64'(lsu_req_valid), 64'd0);
    check_eq("lat_t2_stall", 64'(stall), 64'd1);
    check_eq("lat_t2_res", 64'(res_valid), 64'd0);
    cyc();
    check_eq("lat_t3_res", 64'(res_valid), 64'd1);
    check_eq("lat_t3_stall", 64'(stall), 64'd0);
    cyc();
    check_eq("lat_t4_stall", 64'(stall), 64'd0);
    check_eq("lat_t4_res", 64'(res_valid), 64'd0);
    check_drained();

    // Both lanes: lane1 store then lane2 load.
    start_txn(mk(1'b1, 2'd2, 32'h200, 5'd1), 1'b1, mk(1'b0, 2'd2, 32'h204, 5'd9), 1'b1, 0, 2);
    finish_txn(1'b0);

    // Ready held low for five cycles.
    start_txn(mk(1'b0, 2'd2, 32'h340, 5'd6), 1'b1, z, 1'b0, 5, 1);
    step(); clear_lanes(); sample();
    check_eq("rdy_req0", 64'(lsu_req_valid), 64'd1);
    check_eq("rdy_stall0", 64'(stall), 64'd1);
    for (int k = 1; k < 5; k++) begin
      cyc();
      check_eq("rdy_req", 64'(lsu_req_valid), 64'd1);
      check_eq("rdy_stall", 64'(stall), 64'd1);
    end
    finish_txn(1'b0);

    // Lane1 load completes, lane2 misaligned word is dropped.
    start_txn(mk(1'b0, 2'd2, 32'h300, 5'd3), 1'b1, mk(1'b0, 2'd2, 32'h102, 5'd4), 1'b1, 0, 1);
    finish_txn(1'b0);

    // Byte at odd address and size-3 word; same rd on both lanes.
    start_txn(mk(1'b0, 2'd0, 32'h401, 5'd11), 1'b1, mk(1'b0, 2'd3, 32'h404, 5'd11), 1'b1, 1, 1);
    finish_txn(1'b0);

    // Flush in WAIT, completion three cycles later is swallowed.
    start_txn(mk(1'b0, 2'd2, 32'h500, 5'd12), 1'b1, z, 1'b0, 0, 4);
    step(); clear_lanes(); sample();
    step(); flush = 1'b1; exp_res.delete(); sample();
    check_eq("flw_stall", 64'(stall), 64'd0);
    step(); flush = 1'b0; sample();
    check_eq("drain_stall1", 64'(stall), 64'd1);
    cyc();
    check_eq("drain_stall2", 64'(stall), 64'd1);
    cyc();
    check_eq("drain_stall3", 64'(stall), 64'd1);
    cyc();
    check_eq("drain_idle_stall", 64'(stall), 64'd0);
    check_eq("drain_idle_res", 64'(res_valid), 64'd0);
    ret_q.delete();
    check_drained();
    start_txn(z, 1'b0, mk(1'b0, 2'd1, 32'h602, 5'd13), 1'b1, 0, 1);
    finish_txn(1'b0);

    // Flush in ISSUE before the LSU accepts.
    start_txn(mk(1'b0, 2'd2, 32'h700, 5'd14), 1'b1, z, 1'b0, 3, 1);
    step(); clear_lanes(); flush = 1'b1; sample();
    check_eq("fli_stall", 64'(stall), 64'd0);
    check_eq("fli_req", 64'(lsu_req_valid), 64'd1);
    step(); flush = 1'b0; exp_req.delete(); exp_res.delete(); sample();
    check_eq("fli_idle_req", 64'(lsu_req_valid), 64'd0);
    check_eq("fli_idle_stall", 64'(stall), 64'd0);
    cyc();
    check_eq("fli_idle_req2", 64'(lsu_req_valid), 64'd0);
    check_drained();

    // Reset while waiting on the LSU; stale completion arrives afterwards.
    start_txn(mk(1'b0, 2'd2, 32'h800, 5'd15), 1'b1, z, 1'b0, 0, 3);
    step(); clear_lanes(); sample();
    step(); rst = 1'b1; exp_res.delete(); sample();
    step(); rst = 1'b0; sample();
    check_all_zero("rstw");
    cyc();
    check_eq("stale_stall", 64'(stall), 64'd0);
    cyc();
    check_eq("stale_res", 64'(res_valid), 64'd0);
    check_eq("stale_stall2", 64'(stall), 64'd0);
    ret_q.delete();
    check_drained();

    // Randomized transactions with garbage on the lanes while busy.
    for (int i = 0; i < 60; i++) begin
      logic v1, v2;
      v1 = 1'($urandom_range(0, 1));
      v2 = 1'($urandom_range(0, 1));
      if (!v1 && !v2) v1 = 1'b1;
      start_txn(rand_op(), v1, rand_op(), v2, $urandom_range(0, 3), $urandom_range(1, 3));
      finish_txn(1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) cyc();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
